// File: rtl/pwm_deadtime_leg_if.sv
// Duty-word offer channel between the modulation source (master) and the PWM leg (slave).
// A word moves when duty_valid and duty_ready are both high on a clock edge.
interface pwm_deadtime_leg_if #(
  parameter int CNT_W = 10
) ();
  logic [CNT_W-1:0] duty;
  logic             duty_valid;
  logic             duty_ready;

  modport master (output duty, output duty_valid, input duty_ready);
  modport slave  (input duty, input duty_valid, output duty_ready);
endinterface

// File: rtl/pwm_deadtime_leg.sv
// Single inverter-leg PWM generator: triangle carrier stepped by the rising edges of the
// divided clock, shadowed duty compare, complementary gate outputs with dead-time insertion.
// Optional feature macro: PWM_FAULT_LATCH_EN adds a 'fault' input with a sticky output kill
// that is released by reset, or by enable=0 while fault=0.
module pwm_deadtime_leg #(
  parameter int CNT_W    = 10,
  parameter int PERIOD   = 500,
  parameter int DT_W     = 6,
  parameter int DEADTIME = 20
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             clk_div,
  input  logic             enable,
`ifdef PWM_FAULT_LATCH_EN
  input  logic             fault,
`endif
  pwm_deadtime_leg_if.slave duty_if,
  output logic             pwm_hi,
  output logic             pwm_lo,
  output logic [CNT_W-1:0] carrier,
  output logic             period_start
);

  localparam logic [CNT_W-1:0] PER_C  = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam logic [DT_W-1:0]  DT_C   = DT_W'(DEADTIME);
  localparam logic [DT_W-1:0]  DT0_C  = {DT_W{1'b0}};

  // Requests above the carrier peak would behave exactly like the peak, so pin them there.
  function automatic logic [CNT_W-1:0] clamp_duty(input logic [CNT_W-1:0] v);
    return (v > PER_C) ? PER_C : v;
  endfunction

  logic             div_q;
  logic [CNT_W-1:0] carrier_q, carrier_d;
  logic             dir_dn_q, dir_dn_d;     // 1 while the carrier is counting down
  logic             start_q, start_d;       // next enabled tick opens a new period
  logic             ps_q;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             pend_full_q, pend_full_d;
  logic             ready_q, ready_d;
  logic             raw_q;
  logic [DT_W-1:0]  dt_q, dt_d;
  logic             hi_q, hi_d;
  logic             lo_q, lo_d;

  logic             tick_s;
  logic             pstart_s;
  logic             accept_s;
  logic             xfer_s;
  logic             raw_s;
  logic             edge_s;
  logic             gate_ok_s;
  logic             fault_block_s;

  // One step per rising edge of the divided clock, seen one clk_in cycle late.
  assign tick_s   = clk_div & ~div_q;
  assign accept_s = duty_if.duty_valid & ready_q;
  // Compare uses the registered carrier and the currently applied duty.
  assign raw_s    = (active_q >= PER_C) | (carrier_q < active_q);

`ifdef PWM_FAULT_LATCH_EN
  logic fault_q, fault_d;

  // Fault latch: set by any fault, held while enabled, released by enable=0 with fault low.
  always_comb begin
    fault_d       = fault | (fault_q & enable);
    fault_block_s = fault | fault_q;
  end
`else
  assign fault_block_s = 1'b0;
`endif

  // Carrier stepping: triangle 0..PERIOD..1, held at 0 while disabled.
  always_comb begin
    carrier_d = carrier_q;
    dir_dn_d  = dir_dn_q;
    start_d   = start_q;
    pstart_s  = 1'b0;
    if (!enable) begin
      carrier_d = ZERO_C;
      dir_dn_d  = 1'b0;
      start_d   = 1'b1;
    end else if (tick_s) begin
      if (dir_dn_q) begin
        carrier_d = carrier_q - ONE_C;
        dir_dn_d  = (carrier_q != ONE_C);
      end else begin
        carrier_d = carrier_q + ONE_C;
        dir_dn_d  = (carrier_q == (PER_C - ONE_C));
      end
      pstart_s = (carrier_d == ZERO_C) | start_q;
      start_d  = 1'b0;
    end else begin
      pstart_s = 1'b0;
    end
  end

  // Duty shadowing: one pending slot, copied into the active word at the carrier bottom
  // (or straight away while disabled); a word accepted in that same cycle waits for the next bottom.
  always_comb begin
    xfer_s      = pend_full_q & (pstart_s | ~enable);
    active_d    = active_q;
    pending_d   = pending_q;
    pend_full_d = pend_full_q;
    if (xfer_s) begin
      active_d = pending_q;
    end else begin
      active_d = active_q;
    end
    if (accept_s) begin
      pending_d   = clamp_duty(duty_if.duty);
      pend_full_d = 1'b1;
    end else if (xfer_s) begin
      pending_d   = ZERO_C;
      pend_full_d = 1'b0;
    end else begin
      pending_d   = pending_q;
      pend_full_d = pend_full_q;
    end
    ready_d = ~pend_full_d;
  end

  // Dead-time: every raw edge (and every disabled cycle) reloads the gap counter; a side is
  // only driven once the counter has run out, so both gates are never high together.
  always_comb begin
    edge_s = raw_s ^ raw_q;
    dt_d   = dt_q;
    if (!enable) begin
      dt_d = DT_C;
    end else if (edge_s) begin
      dt_d = DT_C;
    end else if (dt_q != DT0_C) begin
      dt_d = dt_q - DT_W'(1);
    end else begin
      dt_d = DT0_C;
    end
    gate_ok_s = enable & (dt_d == DT0_C) & ~fault_block_s;
    hi_d      = gate_ok_s & raw_s;
    lo_d      = gate_ok_s & ~raw_s;
  end

  // State and registered outputs; reset drives both gates low directly.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      div_q       <= 1'b0;
      carrier_q   <= ZERO_C;
      dir_dn_q    <= 1'b0;
      start_q     <= 1'b1;
      ps_q        <= 1'b0;
      active_q    <= ZERO_C;
      pending_q   <= ZERO_C;
      pend_full_q <= 1'b0;
      ready_q     <= 1'b0;
      raw_q       <= 1'b0;
      dt_q        <= DT_C;
      hi_q        <= 1'b0;
      lo_q        <= 1'b0;
`ifdef PWM_FAULT_LATCH_EN
      fault_q     <= 1'b0;
`endif
    end else begin
      div_q       <= clk_div;
      carrier_q   <= carrier_d;
      dir_dn_q    <= dir_dn_d;
      start_q     <= start_d;
      ps_q        <= pstart_s;
      active_q    <= active_d;
      pending_q   <= pending_d;
      pend_full_q <= pend_full_d;
      ready_q     <= ready_d;
      raw_q       <= raw_s;
      dt_q        <= dt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
`ifdef PWM_FAULT_LATCH_EN
      fault_q     <= fault_d;
`endif
    end
  end

  assign duty_if.duty_ready = ready_q;
  assign pwm_hi             = hi_q;
  assign pwm_lo             = lo_q;
  assign carrier            = carrier_q;
  assign period_start       = ps_q;

endmodule
